system_bus_ctrl: RTL

//  Clocked, parametrised 8088 bus controller; next generation of the combinational system bus.

---
 rtl/system_bus_pkg.sv | 22 ++
 rtl/bus_wait_gen.sv | 27 ++
 rtl/system_bus_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/system_bus_pkg.sv
// Shared types and constants for the clocked 8088 system bus controller.
package system_bus_pkg;

  localparam int unsigned WS_W = 3;

  typedef enum logic [2:0] {
    R_IDLE,
    R_INTA,
    R_RAM,
    R_ROM,
    R_TOUT,
    R_IO,
    R_NONE
  } region_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } bus_state_e;

endpackage

// File: rtl/bus_wait_gen.sv
// Loadable down-counter; o_done marks the last wait-state clock of a bus cycle.
module bus_wait_gen
  import system_bus_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [WS_W-1:0] i_ws,
  output logic            o_done
);

  logic [WS_W-1:0] r_cnt;

  // Loaded with ws-1 so WAIT lasts exactly ws clocks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_ws - WS_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WS_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/system_bus_ctrl.sv
// Clocked 8088 bus controller: latched region decode, wait-state insertion, INTA pairing,
// test-out latch and sticky unmapped-access capture.
module system_bus_ctrl
  import system_bus_pkg::*;
#(
  parameter int unsigned             RAM_AW    = 14,
  parameter int unsigned             ROM_AW    = 14,
  parameter int unsigned             NUM_IO    = 3,
  parameter logic [4*NUM_IO-1:0]     IO_HI     = 12'h642,
  parameter logic [7:0]              TOUT_PORT = 8'h56,
  parameter int unsigned             RAM_WS    = 0,
  parameter int unsigned             ROM_WS    = 1,
  parameter int unsigned             IO_WS     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cpu_rd_n,
  input  logic                  i_cpu_wr_n,
  input  logic                  i_cpu_inta_n,
  input  logic                  i_cpu_iom,
  input  logic [19:0]           i_cpu_addr,
  input  logic [7:0]            i_cpu_dout,
  output logic [7:0]            o_cpu_din,
  output logic                  o_cpu_ready,
  output logic [RAM_AW-1:0]     o_ram_addr,
  output logic                  o_ram_wren,
  input  logic [7:0]            i_ram_q,
  output logic [ROM_AW-1:0]     o_rom_addr,
  input  logic [7:0]            i_rom_q,
  output logic [NUM_IO-1:0]     o_io_cs_n,
  output logic                  o_io_rd_n,
  output logic                  o_io_wr_n,
  output logic [1:0]            o_io_a,
  output logic [7:0]            o_io_wdata,
  input  logic [8*NUM_IO-1:0]   i_io_rdata,
  output logic                  o_pic_inta_n,
  output logic [7:0]            o_test_out,
  output logic                  o_bus_err,
  output logic [19:0]           o_err_addr,
  input  logic                  i_err_clr
);

  bus_state_e        r_state;
  region_e           r_region;
  logic [NUM_IO-1:0] r_io_sel;
  logic              r_prev_high;
  logic              r_wr_n_q;
  logic              r_inta_phase;
  logic [7:0]        r_test_out;
  logic              r_bus_err;
  logic [19:0]       r_err_addr;

  logic              w_all_high;
  logic              w_start;
  logic              w_cyc_start;
  region_e           w_dec_region;
  logic [NUM_IO-1:0] w_dec_io;
  logic [WS_W-1:0]   w_dec_ws;
  logic              w_wait_done;
  logic [7:0]        w_io_data;

  assign w_all_high  = i_cpu_rd_n & i_cpu_wr_n & i_cpu_inta_n;
  // r_prev_high resets low so a strobe held through reset never opens a cycle.
  assign w_start     = r_prev_high & ~w_all_high;
  assign w_cyc_start = w_start & (r_state == StIdle);

  always_comb begin
    w_dec_region = R_NONE;
    w_dec_io     = '0;
    if (!i_cpu_inta_n) begin
      w_dec_region = R_INTA;
    end else if (!i_cpu_iom && (i_cpu_addr[19:RAM_AW] == '0)) begin
      w_dec_region = R_RAM;
    end else if (!i_cpu_iom && (&i_cpu_addr[19:ROM_AW])) begin
      w_dec_region = R_ROM;
    end else if (i_cpu_iom && (i_cpu_addr[7:0] == TOUT_PORT)) begin
      w_dec_region = R_TOUT;
    end else if (i_cpu_iom) begin
      // Descending scan so the lowest matching slot wins.
      for (int k = int'(NUM_IO) - 1; k >= 0; k--) begin
        if (i_cpu_addr[7:4] == IO_HI[4*k +: 4]) begin
          w_dec_region = R_IO;
          w_dec_io     = '0;
          w_dec_io[k]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (w_dec_region)
      R_RAM:        w_dec_ws = WS_W'(RAM_WS);
      R_ROM:        w_dec_ws = WS_W'(ROM_WS);
      R_TOUT, R_IO: w_dec_ws = WS_W'(IO_WS);
      default:      w_dec_ws = '0;
    endcase
  end

  bus_wait_gen u_wait_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_cyc_start),
    .i_ws    (w_dec_ws),
    .o_done  (w_wait_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_region <= R_IDLE;
      r_io_sel <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_region <= w_dec_region;
            r_io_sel <= w_dec_io;
            r_state  <= (w_dec_ws != '0) ? StWait : StDone;
          end
        end
        StWait: begin
          if (w_all_high) begin
            r_state  <= StIdle;
            r_region <= R_IDLE;
            r_io_sel <= '0;
          end else if (w_wait_done) begin
            r_state <= StDone;
          end
        end
        StDone: begin
          if (w_all_high) begin
            r_state  <= StIdle;
            r_region <= R_IDLE;
            r_io_sel <= '0;
          end
        end
        default: begin
          r_state  <= StIdle;
          r_region <= R_IDLE;
          r_io_sel <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_high  <= 1'b0;
      r_wr_n_q     <= 1'b1;
      r_inta_phase <= 1'b0;
      r_test_out   <= '0;
    end else begin
      r_prev_high <= w_all_high;
      r_wr_n_q    <= i_cpu_wr_n;
      if (w_cyc_start && (w_dec_region != R_INTA)) begin
        r_inta_phase <= 1'b0;
      end else if ((r_state == StDone) && w_all_high && (r_region == R_INTA)) begin
        r_inta_phase <= ~r_inta_phase;
      end
      // Only a completed cycle may load; an aborted WAIT leaves the latch untouched.
      if ((r_region == R_TOUT) && (r_state == StDone) && i_cpu_wr_n && !r_wr_n_q) begin
        r_test_out <= i_cpu_dout;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_err  <= 1'b0;
      r_err_addr <= '0;
    end else if (i_err_clr) begin
      r_bus_err  <= 1'b0;
      r_err_addr <= '0;
    end else if (w_cyc_start && (w_dec_region == R_NONE) && !r_bus_err) begin
      r_bus_err  <= 1'b1;
      r_err_addr <= i_cpu_addr;
    end
  end

  always_comb begin
    w_io_data = '0;
    for (int k = 0; k < int'(NUM_IO); k++) begin
      if (r_io_sel[k]) begin
        w_io_data = w_io_data | i_io_rdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    case (r_region)
      R_IDLE:  o_cpu_din = '0;
      R_INTA:  o_cpu_din = r_inta_phase ? i_io_rdata[7:0] : 8'hFF;
      R_RAM:   o_cpu_din = i_ram_q;
      R_ROM:   o_cpu_din = i_rom_q;
      R_IO:    o_cpu_din = w_io_data;
      default: o_cpu_din = 8'hFF;
    endcase
  end

  assign o_cpu_ready  = ~((w_cyc_start && (w_dec_ws != '0)) || (r_state == StWait));
  assign o_ram_wren   = (r_region == R_RAM) && (r_state == StDone) && !i_cpu_wr_n;
  assign o_ram_addr   = i_cpu_addr[RAM_AW-1:0];
  assign o_rom_addr   = i_cpu_addr[ROM_AW-1:0];
  assign o_io_cs_n    = (r_state != StIdle) ? ~r_io_sel : '1;
  assign o_io_rd_n    = (r_region == R_IO) ? i_cpu_rd_n : 1'b1;
  assign o_io_wr_n    = (r_region == R_IO) ? i_cpu_wr_n : 1'b1;
  assign o_io_a       = i_cpu_addr[1:0];
  assign o_io_wdata   = i_cpu_dout;
  assign o_pic_inta_n = i_cpu_inta_n;
  assign o_test_out   = r_test_out;
  assign o_bus_err    = r_bus_err;
  assign o_err_addr   = r_err_addr;

endmodule
